tm1638_driver: RTL and testbench

- Write-only serial driver for the TM1638 LED/7-segment board; sits directly downstream of the hex-to-7-segment decoders.
- Takes eight segment bytes (bit0 = segment A … bit6 = G, bit7 = DP), eight discrete LED bits and a brightness level.
- On START, snapshots them and shifts out one complete refresh frame over STB/CLK/DIO: data-set command, address-set + 16 data bytes, display-control command.

---
 rtl/tm1638_driver_if.sv | 24 ++
 rtl/tm1638_driver.sv | 192 +++++++++++++++++++
 tb/tb_tm1638_driver.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tm1638_driver_if.sv
// Request/status and serial-line bundle between a frame requester and the TM1638 driver.
// The driver takes the slave side; whoever requests frames takes the master side.
interface tm1638_driver_if;
  logic        start;
  logic [63:0] digits;
  logic [7:0]  leds;
  logic [2:0]  bright;
  logic        disp_on;
  logic        busy;
  logic        done;
  logic        tm_stb;
  logic        tm_clk;
  logic        tm_dio;

  modport master (
    output start, digits, leds, bright, disp_on,
    input  busy, done, tm_stb, tm_clk, tm_dio
  );

  modport slave (
    input  start, digits, leds, bright, disp_on,
    output busy, done, tm_stb, tm_clk, tm_dio
  );
endinterface

// File: rtl/tm1638_driver.sv
// Write-only TM1638 refresh engine: on start it snapshots the display image and shifts out
// data-set, address-set + 16 data bytes and display-control commands over STB/CLK/DIO.
module tm1638_driver #(
  parameter int CLK_DIV = 12
) (
  input  logic           clk,
  input  logic           rst,
  tm1638_driver_if.slave bus
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_GAP} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic             phase, phase_nxt;   // SHIFT: high half of a bit; GAP: second divider period
  logic [2:0]       bit_idx, bit_nxt;
  logic [4:0]       byte_idx, byte_nxt;
  logic [1:0]       txn, txn_nxt;
  logic             stb, stb_nxt;
  logic             sclk, sclk_nxt;
  logic             dio, dio_nxt;
  logic             done, done_nxt;
  logic             accept, load_bit, div_end;
  logic [4:0]       last_byte;
  logic [7:0]       next_byte;

  logic [63:0] digits_q;
  logic [7:0]  leds_q;
  logic [2:0]  bright_q;
  logic        disp_on_q;

  // Byte idx of transaction t, built from the snapshot taken at accept.
  function automatic logic [7:0] frame_byte(input logic [1:0] t, input logic [4:0] idx);
    logic [7:0] b;
    logic [4:0] k;
    k = idx - 5'd1;
    b = 8'h40;
    case (t)
      2'd0: b = 8'h40;
      2'd1: begin
        if (idx == 5'd0)   b = 8'hC0;
        else if (!k[0])    b = digits_q[{k[3:1], 3'b000} +: 8];
        else               b = {7'b0, leds_q[k[3:1]]};
      end
      default: b = disp_on_q ? {5'b10001, bright_q} : 8'h80;
    endcase
    return b;
  endfunction

  assign div_end   = (div == DIV_LAST);
  assign last_byte = (txn == 2'd1) ? 5'd16 : 5'd0;

  // NOTE: every variable gets a default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    div_nxt   = div_end ? '0 : div + 1'b1;
    phase_nxt = phase;
    bit_nxt   = bit_idx;
    byte_nxt  = byte_idx;
    txn_nxt   = txn;
    stb_nxt   = stb;
    sclk_nxt  = sclk;
    dio_nxt   = dio;
    done_nxt  = 1'b0;
    accept    = 1'b0;
    load_bit  = 1'b0;
    next_byte = 8'h00;

    unique case (state)
      S_IDLE: begin
        div_nxt   = '0;
        phase_nxt = 1'b0;
        stb_nxt   = 1'b1;
        sclk_nxt  = 1'b1;
        dio_nxt   = 1'b1;
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = S_LEAD;
          txn_nxt   = 2'd0;
          byte_nxt  = 5'd0;
          bit_nxt   = 3'd0;
          stb_nxt   = 1'b0;
        end
      end
      S_LEAD: begin
        if (div_end) begin
          state_nxt = S_SHIFT;
          phase_nxt = 1'b0;
          bit_nxt   = 3'd0;
          sclk_nxt  = 1'b0;
          load_bit  = 1'b1;
        end
      end
      S_SHIFT: begin
        if (div_end) begin
          if (!phase) begin
            phase_nxt = 1'b1;
            sclk_nxt  = 1'b1;
          end else if (bit_idx == 3'd7 && byte_idx == last_byte) begin
            state_nxt = S_TRAIL;
            phase_nxt = 1'b0;
            dio_nxt   = 1'b1;
          end else begin
            phase_nxt = 1'b0;
            sclk_nxt  = 1'b0;
            bit_nxt   = bit_idx + 3'd1;
            if (bit_idx == 3'd7) byte_nxt = byte_idx + 5'd1;
            load_bit  = 1'b1;
          end
        end
      end
      S_TRAIL: begin
        if (div_end) begin
          state_nxt = S_GAP;
          phase_nxt = 1'b0;
          stb_nxt   = 1'b1;
        end
      end
      S_GAP: begin
        if (div_end) begin
          phase_nxt = ~phase;
          if (phase) begin
            if (txn == 2'd2) begin
              state_nxt = S_IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = S_LEAD;
              txn_nxt   = txn + 2'd1;
              byte_nxt  = 5'd0;
              stb_nxt   = 1'b0;
            end
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // The new bit goes out together with the falling TM_CLK and holds through the high half.
    if (load_bit) begin
      next_byte = frame_byte(txn_nxt, byte_nxt);
      dio_nxt   = next_byte[bit_nxt];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      div      <= '0;
      phase    <= 1'b0;
      bit_idx  <= 3'd0;
      byte_idx <= 5'd0;
      txn      <= 2'd0;
      stb      <= 1'b1;
      sclk     <= 1'b1;
      dio      <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      div      <= div_nxt;
      phase    <= phase_nxt;
      bit_idx  <= bit_nxt;
      byte_idx <= byte_nxt;
      txn      <= txn_nxt;
      stb      <= stb_nxt;
      sclk     <= sclk_nxt;
      dio      <= dio_nxt;
      done     <= done_nxt;
    end
  end

  // NOTE: the snapshot is deliberately left out of reset; it is only read after an accept loads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      digits_q  <= bus.digits;
      leds_q    <= bus.leds;
      bright_q  <= bus.bright;
      disp_on_q <= bus.disp_on;
    end
  end

  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = done;
  assign bus.tm_stb = stb;
  assign bus.tm_clk = sclk;
  assign bus.tm_dio = dio;

endmodule

// File: tb/tb_tm1638_driver.sv
// Directed bench for tm1638_driver at CLK_DIV=2: a line decoder rebuilds the STB-low windows
// and bytes, and the main sequence compares them with hand-computed frames.
module tb_tm1638_driver;

  localparam int D     = 2;
  localparam int FRAME = 316 * D;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tm1638_driver_if bus ();

  tm1638_driver #(.CLK_DIV(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Line decoder state
  logic [7:0] rx_bytes [$];
  int         rx_lens  [$];
  int         busy_runs[$];
  int         done_cnt  = 0;
  int         proto_err = 0;
  int         win_len   = 0;
  int         bitn      = 0;
  int         run       = 0;
  int         busy_run  = 0;
  logic [7:0] sh        = 8'h00;
  logic       prev_stb  = 1'b1;
  logic       prev_clk  = 1'b1;
  logic       dio_rise  = 1'b1;
  logic       seen_rise = 1'b0;
  logic       mon_clear = 1'b0;

  logic [7:0] exp_frame [19];

  always @(negedge clk) begin
    if (mon_clear) begin
      rx_bytes.delete();
      rx_lens.delete();
      busy_runs.delete();
      done_cnt  = 0;
      proto_err = 0;
      busy_run  = 0;
    end
    if (bus.done === 1'b1) done_cnt++;
    if (bus.busy === 1'b1) busy_run++;
    else if (busy_run > 0) begin
      busy_runs.push_back(busy_run);
      busy_run = 0;
    end
    if (bus.tm_stb === 1'b0) begin
      if (prev_stb === 1'b1) begin
        win_len   = 0;
        bitn      = 0;
        run       = 0;
        seen_rise = 1'b0;
        if (bus.tm_clk !== 1'b1) proto_err++;
      end else if (bus.tm_clk !== prev_clk) begin
        if (bus.tm_clk === 1'b1) begin
          if (run != D) proto_err++;
          sh        = {bus.tm_dio, sh[7:1]};
          dio_rise  = bus.tm_dio;
          seen_rise = 1'b1;
          bitn++;
          if (bitn == 8) begin
            rx_bytes.push_back(sh);
            win_len++;
            bitn = 0;
          end
        end else if (seen_rise && run != D) begin
          proto_err++;
        end
        run = 1;
      end else begin
        run++;
        if (bus.tm_clk === 1'b1 && seen_rise && run <= D && bus.tm_dio !== dio_rise) proto_err++;
      end
    end else if (prev_stb === 1'b0) begin
      rx_lens.push_back(win_len);
      if (bitn != 0) proto_err++;
    end
    prev_stb = bus.tm_stb;
    prev_clk = bus.tm_clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic clear_monitor();
    mon_clear = 1'b1;
    tick();
    mon_clear = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.done !== 1'b1 && n < FRAME + 50) begin
      tick();
      n++;
    end
    check({tag, " done seen"}, bus.done, 1'b1);
    check({tag, " busy low at done"}, bus.busy, 1'b0);
  endtask

  task automatic check_busy_run(input string tag);
    int got;
    got = (busy_runs.size() > 0) ? busy_runs.pop_front() : -1;
    check({tag, " busy length"}, got, FRAME);
  endtask

  task automatic check_frame(input string tag);
    int got;
    for (int w = 0; w < 3; w++) begin
      got = (rx_lens.size() > 0) ? rx_lens.pop_front() : -1;
      check($sformatf("%s window%0d length", tag, w), got, (w == 1) ? 17 : 1);
    end
    for (int b = 0; b < 19; b++) begin
      got = (rx_bytes.size() > 0) ? int'(rx_bytes.pop_front()) : -1;
      check($sformatf("%s byte%0d", tag, b), got, {24'd0, exp_frame[b]});
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    bus.start   = 1'b0;
    bus.digits  = 64'd0;
    bus.leds    = 8'd0;
    bus.bright  = 3'd0;
    bus.disp_on = 1'b0;
    #1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state and a quiet idle period
    check("reset stb", bus.tm_stb, 1'b1);
    check("reset busy", bus.busy, 1'b0);
    bad = 1'b0;
    repeat (100) begin
      tick();
      bad |= (bus.tm_stb !== 1'b1) || (bus.tm_clk !== 1'b1) || (bus.tm_dio !== 1'b1)
           || (bus.busy !== 1'b0) || (bus.done !== 1'b0);
    end
    check("idle lines quiet", bad, 1'b0);

    // Frame A: display on, brightness 3
    clear_monitor();
    bus.digits  = 64'h0706_5B4F_665D_7D3F;
    bus.leds    = 8'hA5;
    bus.bright  = 3'd3;
    bus.disp_on = 1'b1;
    pulse_start();
    check("A busy after start", bus.busy, 1'b1);
    check("A stb after start", bus.tm_stb, 1'b0);
    wait_done("A");
    tick();
    check("A done one cycle", bus.done, 1'b0);
    check_busy_run("A");
    check("A done count", done_cnt, 1);
    check("A protocol", proto_err, 0);
    exp_frame = '{8'h40, 8'hC0, 8'h3F, 8'h01, 8'h7D, 8'h00, 8'h5D, 8'h01, 8'h66, 8'h00,
                  8'h4F, 8'h00, 8'h5B, 8'h01, 8'h06, 8'h00, 8'h07, 8'h01, 8'h8B};
    check_frame("A");

    // Frame B: blanked display, plus a start and input changes while busy
    clear_monitor();
    bus.digits  = 64'h0123_4567_89AB_CDEF;
    bus.leds    = 8'h3C;
    bus.bright  = 3'd7;
    bus.disp_on = 1'b0;
    pulse_start();
    repeat (100) tick();
    bus.digits  = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.leds    = 8'h00;
    bus.bright  = 3'd0;
    bus.disp_on = 1'b1;
    pulse_start();
    wait_done("B");
    tick();
    check_busy_run("B");
    check("B done count", done_cnt, 1);
    check("B protocol", proto_err, 0);
    exp_frame = '{8'h40, 8'hC0, 8'hEF, 8'h00, 8'hCD, 8'h00, 8'hAB, 8'h01, 8'h89, 8'h01,
                  8'h67, 8'h01, 8'h45, 8'h01, 8'h23, 8'h00, 8'h01, 8'h00, 8'h80};
    check_frame("B");

    // Back-to-back frames with start held; digits change mid-frame
    clear_monitor();
    bus.digits  = 64'h0706_5B4F_665D_7D3F;
    bus.leds    = 8'hA5;
    bus.bright  = 3'd5;
    bus.disp_on = 1'b1;
    bus.start   = 1'b1;
    tick();
    repeat (300) tick();
    bus.digits  = 64'h0123_4567_89AB_CDEF;
    wait_done("BB1");
    tick();
    check("BB second stb low", bus.tm_stb, 1'b0);
    check("BB second busy", bus.busy, 1'b1);
    bus.start = 1'b0;
    wait_done("BB2");
    tick();
    check_busy_run("BB1");
    check_busy_run("BB2");
    check("BB done count", done_cnt, 2);
    check("BB protocol", proto_err, 0);
    exp_frame = '{8'h40, 8'hC0, 8'h3F, 8'h01, 8'h7D, 8'h00, 8'h5D, 8'h01, 8'h66, 8'h00,
                  8'h4F, 8'h00, 8'h5B, 8'h01, 8'h06, 8'h00, 8'h07, 8'h01, 8'h8D};
    check_frame("BB1");
    exp_frame = '{8'h40, 8'hC0, 8'hEF, 8'h01, 8'hCD, 8'h00, 8'hAB, 8'h01, 8'h89, 8'h00,
                  8'h67, 8'h00, 8'h45, 8'h01, 8'h23, 8'h00, 8'h01, 8'h01, 8'h8D};
    check_frame("BB2");

    // Reset during T2 byte 5 aborts the frame without DONE
    clear_monitor();
    bus.digits  = 64'h0706_5B4F_665D_7D3F;
    bus.leds    = 8'hA5;
    bus.bright  = 3'd3;
    bus.disp_on = 1'b1;
    pulse_start();
    repeat (208) tick();
    rst = 1'b1;
    tick();
    check("abort stb", bus.tm_stb, 1'b1);
    check("abort clk", bus.tm_clk, 1'b1);
    check("abort dio", bus.tm_dio, 1'b1);
    check("abort busy", bus.busy, 1'b0);
    check("abort done", bus.done, 1'b0);
    rst = 1'b0;
    repeat (3) tick();
    check("abort done count", done_cnt, 0);

    // Fresh frame after the abort
    clear_monitor();
    pulse_start();
    wait_done("R");
    tick();
    check_busy_run("R");
    check("R done count", done_cnt, 1);
    check("R protocol", proto_err, 0);
    exp_frame = '{8'h40, 8'hC0, 8'h3F, 8'h01, 8'h7D, 8'h00, 8'h5D, 8'h01, 8'h66, 8'h00,
                  8'h4F, 8'h00, 8'h5B, 8'h01, 8'h06, 8'h00, 8'h07, 8'h01, 8'h8B};
    check_frame("R");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
